ddr_host_req_queue: RTL and testbench
=====================================

DDR_HOST_REQ_QUEUE -- requirements
Module: ddr_host_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth (power of 2, >=2).
REQ-002 Parameter ACK_TIMEOUT, default 16, max cycles waiting for controller acceptance.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  queue can accept; equals not-full.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  25  {row[12:0], ba[1:0], col[9:0]}, i.e. [24:12] row, [11:10] bank, [9:0] col.
REQ-009 req_wdata  in  16  write data, stored with request.
REQ-010 rsp_valid  out  1  one-cycle pulse: read data valid.
REQ-011 rsp_rdata  out  16  read data, held until next rsp_valid.
REQ-012 err_timeout  out  1  one-cycle pulse: request dropped, controller never went busy.
REQ-013 init_done  in  1  controller initialisation complete.
REQ-014 ctrl_busy  in  1  controller executing a command.
REQ-015 data_out_rdy  in  1  controller read data valid on sys_rdata.
REQ-016 sys_rdata  in  16  read data from controller system bus.
REQ-017 addr_strobe  out  1  one-cycle request strobe to controller.
REQ-018 sys_addr_row / sys_ba / sys_addr_col  out  13 / 2 / 10  registered request address.
REQ-019 rd_wr_req  out  1  registered direction, 1 = write.
REQ-020 sys_wdata  out  16  write data for controller system bus.
REQ-021 sys_wdata_oe  out  1  drive enable for sys_wdata onto shared sys_data bus.

Function
REQ-022 FIFO SHALL store {we, addr, wdata} (42 bits); push when req_valid && req_ready.
REQ-023 Pop and push in same cycle SHALL leave count unchanged; push when full SHALL be ignored (req_ready low).
REQ-024 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-025 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-026 IDLE -> ISSUE when FIFO non-empty && init_done && !ctrl_busy; head popped and registered onto sys_* outputs in that transition cycle.
REQ-027 ISSUE: addr_strobe=1 for exactly one cycle; next state WAIT_ACK; ack counter cleared.
REQ-028 WAIT_ACK: ctrl_busy=1 -> WAIT_DONE; else counter increments; counter reaching ACK_TIMEOUT-1 -> IDLE with err_timeout pulse, request discarded.
REQ-029 WAIT_DONE read: data_out_rdy=1 captures sys_rdata into rsp_rdata, rsp_valid pulses next cycle; return to IDLE when ctrl_busy=0 and data captured.
REQ-030 WAIT_DONE write: sys_wdata_oe=1 from ISSUE through WAIT_DONE until ctrl_busy=0, then IDLE.
REQ-031 data_out_rdy outside a read WAIT_DONE SHALL be ignored.
REQ-032 init_done low SHALL block new issue only; in-flight request completes.
REQ-033 Minimum issue spacing: one IDLE cycle between consecutive addr_strobe pulses.
REQ-034 sys_addr_*/rd_wr_req/sys_wdata SHALL be stable from ISSUE until return to IDLE.

Reset
REQ-035 rst=0 at clock edge: FIFO empty, FSM IDLE, counters 0.
REQ-036 Reset values: req_ready 0 during reset then 1, rsp_valid 0, rsp_rdata 0, err_timeout 0, addr_strobe 0, sys_addr_* 0, rd_wr_req 0, sys_wdata 0, sys_wdata_oe 0.
REQ-037 Reset mid-operation SHALL abort in-flight request and flush FIFO without rsp_valid.

Structure
REQ-038 Address field widths (13/2/10), bit offsets, and FSM state encodings SHALL live in the shared DDR_parameters include.
REQ-039 FIFO SHALL be a sub-module ddr_req_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-040 Write 0x12A5 to row 0x0003, ba 2, col 0x010 with init_done=1 -> single addr_strobe, rd_wr_req=1, sys_ba=2, sys_wdata_oe high until ctrl_busy falls.
REQ-041 Read, model returns 0xBEEF with data_out_rdy -> rsp_valid one pulse, rsp_rdata=0xBEEF.
REQ-042 Push 5 requests DEPTH=4 while init_done=0 -> req_ready low after 4th, 5th not stored; raise init_done -> exactly 4 strobes in order.
REQ-043 Controller never asserts ctrl_busy -> err_timeout pulse 16 cycles after strobe, next request issued.
REQ-044 Push while popping with FIFO full -> count stays 4, no data loss or duplication.
REQ-045 Assert rst=0 in WAIT_DONE of a read -> all outputs at reset values next cycle, no rsp_valid, FIFO empty.

Source files
------------

// File: rtl/ddr_host_req_queue_pkg.sv
// ddr_host_req_queue_pkg
// Shared DDR host-queue parameters: address field widths and bit offsets,
// data width, the queued request record and the issue FSM state encoding.
// Helper functions split a packed host address into row / bank / column.

package ddr_host_req_queue_pkg;

    localparam int unsigned ROW_W  = 13;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned ADDR_W = ROW_W + BA_W + COL_W;
    localparam int unsigned DATA_W = 16;

    // Host address layout: {row, ba, col}
    localparam int unsigned COL_LSB = 0;
    localparam int unsigned BA_LSB  = COL_LSB + COL_W;
    localparam int unsigned ROW_LSB = BA_LSB + BA_W;

    // Queued request: {we, addr, wdata}
    localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitAck  = 2'd2,
        StWaitDone = 2'd3
    } state_e;

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[ROW_LSB +: ROW_W];
    endfunction

    function automatic logic [BA_W-1:0] addr_ba(input logic [ADDR_W-1:0] addr);
        return addr[BA_LSB +: BA_W];
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[COL_LSB +: COL_W];
    endfunction

endpackage

// File: rtl/ddr_host_req_queue_if.sv
// ddr_host_req_queue_if
// Bundles the host request/response handshake and the controller system-bus
// signals of the DDR host request queue.
//   master : the environment (host + controller) side
//   slave  : the queue side
// Host:       req_valid/req_ready/req_we/req_addr/req_wdata, rsp_valid/rsp_rdata,
//             err_timeout
// Controller: init_done, ctrl_busy, data_out_rdy, sys_rdata, addr_strobe,
//             sys_addr_row/sys_ba/sys_addr_col, rd_wr_req, sys_wdata, sys_wdata_oe

interface ddr_host_req_queue_if;
    import ddr_host_req_queue_pkg::*;

    // Host side
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              err_timeout;

    // Controller side
    logic              init_done;
    logic              ctrl_busy;
    logic              data_out_rdy;
    logic [DATA_W-1:0] sys_rdata;
    logic              addr_strobe;
    logic [ROW_W-1:0]  sys_addr_row;
    logic [BA_W-1:0]   sys_ba;
    logic [COL_W-1:0]  sys_addr_col;
    logic              rd_wr_req;
    logic [DATA_W-1:0] sys_wdata;
    logic              sys_wdata_oe;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output init_done, ctrl_busy, data_out_rdy, sys_rdata,
        input  req_ready, rsp_valid, rsp_rdata, err_timeout,
        input  addr_strobe, sys_addr_row, sys_ba, sys_addr_col, rd_wr_req,
        input  sys_wdata, sys_wdata_oe
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  init_done, ctrl_busy, data_out_rdy, sys_rdata,
        output req_ready, rsp_valid, rsp_rdata, err_timeout,
        output addr_strobe, sys_addr_row, sys_ba, sys_addr_col, rd_wr_req,
        output sys_wdata, sys_wdata_oe
    );

endinterface

// File: rtl/ddr_req_fifo.sv
// ddr_req_fifo
// Synchronous first-word-fall-through FIFO. rdata always shows the head entry.
//   clk, rst (sync, active low)
//   push/wdata : write when not full (push while full is dropped)
//   pop        : remove head when not empty
//   full, empty, count (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.

module ddr_req_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; contents are only read when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ddr_host_req_queue.sv
// ddr_host_req_queue
// Queues host read/write requests and issues them one at a time to a DDR
// controller system bus. A request is popped in IDLE, registered onto the
// sys_* outputs, strobed for one cycle, then the queue waits for the
// controller to go busy (or times out) and for the command to complete.
// Read data is captured once per read and reported with a one-cycle rsp_valid.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : ddr_host_req_queue_if.slave (host handshake + controller bus)
// DEPTH: FIFO depth (power of two, >= 2). ACK_TIMEOUT: acceptance window (>= 2).

module ddr_host_req_queue
    import ddr_host_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ddr_host_req_queue_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    // FIFO
    logic [REQ_W-1:0] fifo_wdata;
    logic [REQ_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    req_t             head;

    // FSM and registered outputs
    state_e           state_q;
    logic [ACK_W-1:0] ack_cnt_q;
    logic [ACK_W-1:0] ack_next;
    logic             rd_captured_q;
    logic             addr_strobe_q;
    logic [ROW_W-1:0] row_q;
    logic [BA_W-1:0]  ba_q;
    logic [COL_W-1:0] col_q;
    logic             we_q;
    logic [DATA_W-1:0] wdata_q;
    logic             wdata_oe_q;
    logic             rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic             err_timeout_q;
    logic             issue;

    assign fifo_wdata = {bus.req_we, bus.req_addr, bus.req_wdata};
    assign head       = req_t'(fifo_rdata);

    // Not ready while held in reset, otherwise simply not-full.
    assign bus.req_ready = rst && !fifo_full;
    assign fifo_push     = bus.req_valid && bus.req_ready;

    assign issue    = (state_q == StIdle) && !fifo_empty && bus.init_done && !bus.ctrl_busy;
    assign fifo_pop = issue;
    assign ack_next = ack_cnt_q + 1'b1;

    ddr_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            ack_cnt_q     <= '0;
            rd_captured_q <= 1'b0;
            addr_strobe_q <= 1'b0;
            row_q         <= '0;
            ba_q          <= '0;
            col_q         <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wdata_oe_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            addr_strobe_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q       <= StIssue;
                        addr_strobe_q <= 1'b1;
                        row_q         <= addr_row(head.addr);
                        ba_q          <= addr_ba(head.addr);
                        col_q         <= addr_col(head.addr);
                        we_q          <= head.we;
                        wdata_q       <= head.wdata;
                        // Write data drives the shared bus from ISSUE onward.
                        wdata_oe_q    <= head.we;
                        rd_captured_q <= 1'b0;
                    end
                end

                StIssue: begin
                    state_q   <= StWaitAck;
                    ack_cnt_q <= '0;
                end

                StWaitAck: begin
                    if (bus.ctrl_busy) begin
                        state_q <= StWaitDone;
                    end else if (ack_next == ACK_LAST) begin
                        // Controller never accepted: drop the request.
                        state_q       <= StIdle;
                        err_timeout_q <= 1'b1;
                        wdata_oe_q    <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_next;
                    end
                end

                StWaitDone: begin
                    if (!we_q) begin
                        // Only the first data_out_rdy of a read is taken.
                        if (bus.data_out_rdy && !rd_captured_q) begin
                            rsp_rdata_q   <= bus.sys_rdata;
                            rsp_valid_q   <= 1'b1;
                            rd_captured_q <= 1'b1;
                        end
                        if (!bus.ctrl_busy && (rd_captured_q || bus.data_out_rdy)) begin
                            state_q <= StIdle;
                        end
                    end else if (!bus.ctrl_busy) begin
                        state_q    <= StIdle;
                        wdata_oe_q <= 1'b0;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.addr_strobe  = addr_strobe_q;
    assign bus.sys_addr_row = row_q;
    assign bus.sys_ba       = ba_q;
    assign bus.sys_addr_col = col_q;
    assign bus.rd_wr_req    = we_q;
    assign bus.sys_wdata    = wdata_q;
    assign bus.sys_wdata_oe = wdata_oe_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.err_timeout  = err_timeout_q;

    fifo_count_bound: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ddr_host_req_queue.sv
// tb_ddr_host_req_queue
// Scoreboarded bench: accepted requests and expected read data are queued at
// drive time; a negedge monitor pops and compares on addr_strobe / rsp_valid.
// A small controller model answers strobes (normal / never busy / stuck busy).

module tb_ddr_host_req_queue;
    import ddr_host_req_queue_pkg::*;

    logic clk;
    logic rst;

    ddr_host_req_queue_if bus_if ();

    ddr_host_req_queue #(
        .DEPTH       (4),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [REQ_W-1:0]  exp_req_q [$];
    logic [DATA_W-1:0] exp_rsp_q [$];

    int strobe_cnt = 0;
    int rsp_cnt    = 0;
    int err_cnt    = 0;
    int ctrl_mode  = 0;  // 0 normal, 1 never busy, 2 busy forever

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'h1234;
    endfunction

    task automatic push_req(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd);
        int n = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        while (!bus_if.req_ready && n < 300) begin
            tick();
            n++;
        end
        if (bus_if.req_ready) begin
            exp_req_q.push_back({we, addr, wd});
            if (!we) exp_rsp_q.push_back(rd_fn(addr));
        end else begin
            check_eq("push_ready", bus_if.req_ready, 1);
        end
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("strobe_count", strobe_cnt, target);
    endtask

    task automatic wait_rsps(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("rsp_count", rsp_cnt, target);
    endtask

    task automatic wait_strobe_edge(input int budget);
        int n = 0;
        while (!bus_if.addr_strobe && n < budget) begin
            tick();
            n++;
        end
        check_eq("strobe_seen", bus_if.addr_strobe, 1);
    endtask

    function automatic logic [63:0] out_vec();
        return {bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.err_timeout, bus_if.addr_strobe,
                bus_if.sys_addr_row, bus_if.sys_ba, bus_if.sys_addr_col, bus_if.rd_wr_req,
                bus_if.sys_wdata, bus_if.sys_wdata_oe};
    endfunction

    // Controller model
    initial begin
        forever begin
            tick();
            if (bus_if.addr_strobe && ctrl_mode != 1) begin
                tick();
                bus_if.ctrl_busy = 1'b1;
                if (ctrl_mode == 0) begin
                    tick();
                    if (!bus_if.rd_wr_req) begin
                        bus_if.sys_rdata    = rd_fn({bus_if.sys_addr_row, bus_if.sys_ba,
                                                     bus_if.sys_addr_col});
                        bus_if.data_out_rdy = 1'b1;
                        tick();
                        bus_if.data_out_rdy = 1'b0;
                    end
                    tick();
                    tick();
                    bus_if.ctrl_busy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_strobe = 1'b0;
        logic prev_rsp    = 1'b0;
        logic prev_err    = 1'b0;
        logic pending;
        logic [REQ_W-1:0]  er;
        logic [DATA_W-1:0] ed;
        forever begin
            @(negedge clk);
            if (bus_if.addr_strobe) begin
                strobe_cnt++;
                check_eq("strobe_width", prev_strobe, 0);
                pending = (exp_req_q.size() != 0);
                check_eq("strobe_pending", pending, 1);
                if (pending) begin
                    er = exp_req_q.pop_front();
                    check_eq("strobe_req",
                             {bus_if.rd_wr_req, bus_if.sys_addr_row, bus_if.sys_ba,
                              bus_if.sys_addr_col, bus_if.sys_wdata}, er);
                end
            end
            if (bus_if.rsp_valid) begin
                rsp_cnt++;
                check_eq("rsp_width", prev_rsp, 0);
                pending = (exp_rsp_q.size() != 0);
                check_eq("rsp_pending", pending, 1);
                if (pending) begin
                    ed = exp_rsp_q.pop_front();
                    check_eq("rsp_data", bus_if.rsp_rdata, ed);
                end
            end
            if (bus_if.err_timeout) begin
                err_cnt++;
                check_eq("err_width", prev_err, 0);
            end
            prev_strobe = bus_if.addr_strobe;
            prev_rsp    = bus_if.rsp_valid;
            prev_err    = bus_if.err_timeout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int ebase;
        int n;
        logic busy_seen;
        logic oe_ok;

        rst                 = 1'b0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_we       = 1'b0;
        bus_if.req_addr     = '0;
        bus_if.req_wdata    = '0;
        bus_if.init_done    = 1'b0;
        bus_if.ctrl_busy    = 1'b0;
        bus_if.data_out_rdy = 1'b0;
        bus_if.sys_rdata    = '0;

        // Reset state
        repeat (3) tick();
        check_eq("reset_outputs", out_vec(), 64'd0);
        check_eq("reset_ready", bus_if.req_ready, 0);
        rst = 1'b1;
        tick();
        check_eq("ready_after_reset", bus_if.req_ready, 1);

        // Single write
        bus_if.init_done = 1'b1;
        base = strobe_cnt;
        push_req(1'b1, {13'h0003, 2'd2, 10'h010}, 16'h12A5);
        wait_strobe_edge(20);
        check_eq("wr_dir", bus_if.rd_wr_req, 1);
        check_eq("wr_ba", bus_if.sys_ba, 2);
        check_eq("wr_oe_at_strobe", bus_if.sys_wdata_oe, 1);
        busy_seen = 1'b0;
        oe_ok     = 1'b1;
        n         = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus_if.ctrl_busy) busy_seen = 1'b1;
            else if (busy_seen) break;
            if (!bus_if.sys_wdata_oe) oe_ok = 1'b0;
        end
        check_eq("wr_oe_held", oe_ok, 1);
        check_eq("wr_busy_fell", busy_seen && !bus_if.ctrl_busy, 1);
        check_eq("wr_oe_at_fall", bus_if.sys_wdata_oe, 1);
        @(negedge clk);
        check_eq("wr_oe_release", bus_if.sys_wdata_oe, 0);
        repeat (10) tick();
        check_eq("wr_single_strobe", strobe_cnt, base + 1);

        // Single read returning 0xBEEF
        rbase = rsp_cnt;
        push_req(1'b0, 25'h000ACDB, 16'h0000);
        wait_rsps(rbase + 1, 50);
        repeat (4) tick();
        check_eq("rd_beef_held", bus_if.rsp_rdata, 16'hBEEF);

        // Fill past full while init_done is low
        bus_if.init_done = 1'b0;
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 25'(32'h100 + i * 32'h421), 16'(32'hA000 + i));
        end
        check_eq("ready_low_full", bus_if.req_ready, 0);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 25'h1FFFFFF;
        bus_if.req_wdata = 16'hDEAD;
        tick();
        bus_if.req_valid = 1'b0;
        repeat (5) tick();
        check_eq("no_issue_uninit", strobe_cnt, base);
        bus_if.init_done = 1'b1;
        wait_strobes(base + 4, 200);
        repeat (20) tick();
        check_eq("fifth_dropped", strobe_cnt, base + 4);
        check_eq("sb_req_drained", exp_req_q.size(), 0);

        // Sustained push while popping from a full FIFO
        bus_if.init_done = 1'b0;
        base  = strobe_cnt;
        rbase = rsp_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) bus_if.init_done = 1'b1;
            push_req(i[0], 25'(i * 37 + 5), 16'(i * 4099));
        end
        wait_strobes(base + 10, 400);
        wait_rsps(rbase + 5, 400);

        // Controller never accepts -> timeout, then next request issues
        bus_if.init_done = 1'b0;
        ctrl_mode = 1;
        base  = strobe_cnt;
        rbase = rsp_cnt;
        ebase = err_cnt;
        push_req(1'b1, 25'h0123456, 16'h5A5A);
        push_req(1'b0, 25'h0007777, 16'h0000);
        bus_if.init_done = 1'b1;
        wait_strobe_edge(20);
        n = 0;
        while (!bus_if.err_timeout && n < 40) begin
            tick();
            n++;
        end
        check_eq("err_latency", n, 16);
        ctrl_mode = 0;
        wait_strobes(base + 2, 60);
        wait_rsps(rbase + 1, 60);
        check_eq("err_count", err_cnt, ebase + 1);

        // Reset while a read sits in WAIT_DONE with more requests queued
        ctrl_mode = 2;
        push_req(1'b0, 25'h0004321, 16'h0000);
        wait_strobe_edge(20);
        repeat (3) tick();
        push_req(1'b1, 25'h0000AAA, 16'h1111);
        push_req(1'b0, 25'h0000BBB, 16'h0000);
        base  = strobe_cnt;
        rbase = rsp_cnt;
        rst   = 1'b0;
        exp_req_q.delete();
        exp_rsp_q.delete();
        tick();
        check_eq("midreset_outputs", out_vec(), 64'd0);
        check_eq("midreset_ready", bus_if.req_ready, 0);
        rst              = 1'b1;
        bus_if.ctrl_busy = 1'b0;
        ctrl_mode        = 0;
        tick();
        check_eq("midreset_ready_back", bus_if.req_ready, 1);
        repeat (15) tick();
        check_eq("midreset_no_strobe", strobe_cnt, base);
        check_eq("midreset_no_rsp", rsp_cnt, rbase);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
